// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared widths, state encoding and FIFO entry type for the fetch path
package rv_fetch_pkg;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
    typedef enum logic [1:0] {FETCH, DRAIN, HALT} fetch_state_e;
    typedef struct packed {
        logic [INST_W-1:0] pc;
        logic [INST_W-1:0] data;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of {pc, data} entries with flush, no bypass
// Ports: clk, rst_n (async active-low); flush clears all entries and wins over push/pop;
//        push/pushEntry write at tail; pop advances head; head is the oldest entry;
//        count is the current fill level (0..DEPTH).
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 pushEntry,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rdPtr, wrPtr;
    // storage needs no reset: count gates every read of it
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wrPtr] <= pushEntry;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop) rdPtr <= rdPtr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign head = mem[rdPtr];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-limited instruction prefetcher with redirect flush and stale-response drop
// Ports: clk, rst_n (async active-low);
//        mem_req_valid/ready/addr: word-aligned read requests to instruction memory;
//        mem_resp_valid/data: in-order responses, always accepted;
//        inst_valid/ready/data/pc: FIFO head presented downstream;
//        redirect_valid/pc: one-cycle redirect pulse and new fetch address.
// Optional: FETCH_MISALIGN_CHECK_EN adds output fetch_misalign; a misaligned redirect
//           parks the unit in HALT until the next aligned redirect.
module instr_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_misalign
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    fetch_state_e state, stateNext;
    logic [INST_W-1:0] fetchPc, respPc, alignedPc;
    logic [OW-1:0] outstanding, outNext, drop, dropNext;
    logic [CW-1:0] count, cntNext;
    logic reqFire, push, pop, misaligned, reqNext;
    fetch_entry_t head;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .pushEntry ({respPc, mem_resp_data}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Next-state values feed the registered request valid, so it holds steady until accepted.
    always_comb begin
        reqFire = mem_req_valid && mem_req_ready;
        pop = inst_valid && inst_ready;
        push = mem_resp_valid && drop == '0 && !redirect_valid;
        alignedPc = redirect_pc & ~32'h3;
`ifdef FETCH_MISALIGN_CHECK_EN
        misaligned = redirect_pc[1:0] != 2'b00;
`else
        misaligned = 1'b0;
`endif
        outNext = outstanding + OW'(reqFire) - OW'(mem_resp_valid);
        // on redirect everything still in flight after this edge is stale
        dropNext = redirect_valid ? outNext : (mem_resp_valid && drop != '0) ? drop - OW'(1) : drop;
        stateNext = redirect_valid ? (misaligned ? HALT : (dropNext != '0 ? DRAIN : FETCH))
                  : (state == DRAIN && dropNext == '0) ? FETCH : state;
        cntNext = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
        reqNext = stateNext == FETCH && int'(cntNext) + int'(outNext) < FIFO_DEPTH
                  && int'(outNext) < MAX_OUTSTANDING;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            fetchPc <= RESET_PC;
            respPc <= RESET_PC;
            outstanding <= '0;
            drop <= '0;
            mem_req_valid <= 1'b0;
        end else begin
            state <= stateNext;
            outstanding <= outNext;
            drop <= dropNext;
            mem_req_valid <= reqNext;
            fetchPc <= redirect_valid ? alignedPc : reqFire ? fetchPc + 32'd4 : fetchPc;
            respPc <= redirect_valid ? alignedPc : push ? respPc + 32'd4 : respPc;
        end
    end

    assign mem_req_addr = fetchPc;
    assign inst_valid = count != '0;
    assign inst_data = inst_valid ? head.data : '0;
    assign inst_pc = inst_valid ? head.pc : '0;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign fetch_misalign = state == HALT;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized and directed bench with an epoch-based reference model
module tb_instr_fetch_unit;
    localparam int          FIFO_DEPTH = 4;
    localparam int          MAX_OUT    = 2;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    instr_fetch_unit #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // instruction memory: in-order responses, per-request latency
    typedef struct {logic [31:0] addr; int due;} memReq_t;
    memReq_t pend[$];
    int lastDue = 0;
    int memLat = 1;
    bit latRand = 1'b0;
    bit holdAt8 = 1'b0;

    // reference model: a response is kept iff its request was issued in the current redirect epoch
    typedef struct {logic [31:0] addr; int epoch;} tag_t;
    typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;
    tag_t mTags[$];
    ent_t mQ[$];
    logic [31:0] mPc;
    int mEpoch;
    bit mHalt, mLive;

    function automatic bit expReq();
        int stale = 0;
        foreach (mTags[i]) if (mTags[i].epoch != mEpoch) stale++;
        return mLive && !mHalt && stale == 0 && (mQ.size() + mTags.size() < FIFO_DEPTH)
               && mTags.size() < MAX_OUT;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        tag_t t;
        bit xfer, keep;
        if (!rst_n) begin
            mTags.delete();
            mQ.delete();
            mPc = RESET_PC;
            mEpoch = 0;
            mHalt = 1'b0;
            mLive = 1'b0;
        end else begin
            xfer = expReq() && mem_req_ready;
            keep = 1'b0;
            if (mem_resp_valid) begin
                checks++;
                if (mTags.size() == 0) begin
                    errors++;
                    $display("FAIL resp_without_request: got response, expected none outstanding (cycle %0d)", cyc);
                end else begin
                    t = mTags.pop_front();
                    keep = t.epoch == mEpoch && !redirect_valid;
                end
            end
            if (xfer) mTags.push_back('{addr: mPc, epoch: mEpoch});
            if (redirect_valid) begin
                mQ.delete();
                mEpoch++;
                mPc = redirect_pc & ~32'h3;
`ifdef FETCH_MISALIGN_CHECK_EN
                mHalt = redirect_pc[1:0] != 2'b00;
`endif
            end else begin
                if (mQ.size() != 0 && inst_ready) void'(mQ.pop_front());
                if (keep) mQ.push_back('{pc: t.addr, data: memWord(t.addr)});
                if (xfer) mPc += 32'd4;
                checks++;
                if (mQ.size() > FIFO_DEPTH) begin
                    errors++;
                    $display("FAIL fifo_overflow: got %0d entries, expected at most %0d", mQ.size(), FIFO_DEPTH);
                end
            end
            mLive = 1'b1;
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        bit ev;
        if (rst_n) begin
            ev = expReq();
            chk("mem_req_valid", mem_req_valid, ev);
            if (ev) chk("mem_req_addr", mem_req_addr, mPc);
            chk("inst_valid", inst_valid, mQ.size() != 0);
            if (mQ.size() != 0) begin
                chk("inst_pc", inst_pc, mQ[0].pc);
                chk("inst_data", inst_data, mQ[0].data);
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            chk("fetch_misalign", fetch_misalign, mHalt);
`endif
        end
    end

    // logs of what the DUT actually delivered and requested
    logic [31:0] popPc[$], popData[$], reqAddr[$];
    int popCyc[$];
    always @(posedge clk) begin
        if (rst_n) begin
            if (inst_valid && inst_ready && !redirect_valid) begin
                popPc.push_back(inst_pc);
                popData.push_back(inst_data);
                popCyc.push_back(cyc);
            end
            if (mem_req_valid && mem_req_ready) reqAddr.push_back(mem_req_addr);
        end
    end

    function automatic logic [31:0] popAt(input int i);
        return i < popPc.size() ? popPc[i] : 32'hxxxx_xxxx;
    endfunction
    function automatic logic [31:0] dataAt(input int i);
        return i < popData.size() ? popData[i] : 32'hxxxx_xxxx;
    endfunction
    function automatic logic [31:0] reqAt(input int i);
        return i < reqAddr.size() ? reqAddr[i] : 32'hxxxx_xxxx;
    endfunction
    function automatic logic [31:0] cycAt(input int i);
        return i < popCyc.size() ? 32'(popCyc[i]) : 32'hxxxx_xxxx;
    endfunction

    task automatic cycle(input bit rdy, input bit ird, input bit rv = 1'b0, input logic [31:0] rpc = 32'h0);
        int d;
        @(negedge clk);
        cyc++;
        mem_req_ready = rdy && !(holdAt8 && mem_req_addr == 32'h8);
        inst_ready = ird;
        redirect_valid = rv;
        redirect_pc = rpc;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data = memWord(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data = $urandom;
        end
        if (mem_req_valid && mem_req_ready) begin
            d = cyc + (latRand ? int'($urandom_range(1, 4)) : memLat);
            if (d <= lastDue) d = lastDue + 1;
            lastDue = d;
            pend.push_back('{addr: mem_req_addr, due: d});
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        mem_req_ready = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        pend.delete();
        lastDue = cyc;
        repeat (2) @(negedge clk);
        chk("reset_req_valid", mem_req_valid, 1'b0);
        chk("reset_inst_valid", inst_valid, 1'b0);
        chk("reset_inst_data", inst_data, 32'h0);
        chk("reset_inst_pc", inst_pc, 32'h0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit rv;
        logic [31:0] rpc;
        int n0;
        doReset();
        // basic streaming
        memLat = 1;
        popPc.delete(); popData.delete(); popCyc.delete();
        repeat (12) cycle(1, 1);
        chk("stream_pc0", popAt(0), 32'h0);
        chk("stream_pc1", popAt(1), 32'h4);
        chk("stream_pc2", popAt(2), 32'h8);
        chk("stream_pc3", popAt(3), 32'hC);
        chk("stream_data0", dataAt(0), 32'h0000_0013);
        chk("stream_data3", dataAt(3), memWord(32'hC));
        chk("stream_no_gap", cycAt(3) - cycAt(0), 32'd3);
        // backpressure
        cycle(0, 0, 1, 32'h0);
        reqAddr.delete();
        repeat (20) cycle(1, 0);
        chk("bp_req_count", reqAddr.size(), FIFO_DEPTH);
        chk("bp_req_last", reqAt(3), 32'hC);
        chk("bp_req_valid", mem_req_valid, 1'b0);
        chk("bp_inst_valid", inst_valid, 1'b1);
        chk("bp_head_pc", inst_pc, 32'h0);
        popPc.delete(); popData.delete(); popCyc.delete();
        repeat (6) cycle(1, 1);
        chk("bp_pc0", popAt(0), 32'h0);
        chk("bp_pc1", popAt(1), 32'h4);
        chk("bp_pc2", popAt(2), 32'h8);
        chk("bp_pc3", popAt(3), 32'hC);
        // redirect with outstanding requests, latency 3
        memLat = 3;
        cycle(0, 1, 1, 32'h0);
        repeat (10) cycle(1, 1);
        cycle(0, 1, 1, 32'h100);
        popPc.delete(); popData.delete(); popCyc.delete();
        cycle(1, 1);
        chk("drain_no_req", mem_req_valid, 1'b0);
        repeat (15) cycle(1, 1);
        chk("redir_pc0", popAt(0), 32'h100);
        chk("redir_pc1", popAt(1), 32'h104);
        // redirect + response + pop in one cycle
        memLat = 1;
        repeat (10) cycle(1, 1);
        for (int i = 0; i < 20 && !(mem_resp_valid && inst_valid); i++) cycle(1, 1);
        chk("simul_setup", {30'b0, mem_resp_valid, inst_valid}, 32'h3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        inst_ready = 1'b1;
        popPc.delete(); popData.delete(); popCyc.delete();
        repeat (10) cycle(1, 1);
        chk("simul_pc0", popAt(0), 32'h40);
        chk("simul_data0", dataAt(0), memWord(32'h40));
        // memory stall at address 8
        cycle(0, 1, 1, 32'h0);
        holdAt8 = 1'b1;
        for (int i = 0; i < 30 && !(mem_req_valid && mem_req_addr == 32'h8); i++) cycle(1, 1);
        chk("stall_reached", {31'b0, mem_req_valid && mem_req_addr == 32'h8}, 32'h1);
        n0 = reqAddr.size();
        repeat (5) begin
            cycle(1, 1);
            chk("stall_addr", mem_req_addr, 32'h8);
            chk("stall_valid", mem_req_valid, 1'b1);
        end
        chk("stall_no_xfer", reqAddr.size(), n0);
        holdAt8 = 1'b0;
        repeat (3) cycle(1, 1);
        chk("stall_release", reqAt(n0), 32'h8);
`ifdef FETCH_MISALIGN_CHECK_EN
        cycle(1, 1, 1, 32'h102);
        repeat (8) cycle(1, 1);
        chk("halt_flag", fetch_misalign, 1'b1);
        chk("halt_no_req", mem_req_valid, 1'b0);
        chk("halt_no_inst", inst_valid, 1'b0);
        cycle(1, 1, 1, 32'h200);
        popPc.delete(); popData.delete(); popCyc.delete();
        repeat (12) cycle(1, 1);
        chk("halt_cleared", fetch_misalign, 1'b0);
        chk("resume_pc0", popAt(0), 32'h200);
`else
        cycle(0, 1, 1, 32'h102);
        popPc.delete(); popData.delete(); popCyc.delete();
        repeat (12) cycle(1, 1);
        chk("align_force_pc0", popAt(0), 32'h100);
`endif
        // randomized traffic
        latRand = 1'b1;
        repeat (4000) begin
            rv = $urandom_range(0, 99) < 3;
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) rpc = rpc & ~32'h3;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rv, rpc);
        end
        // reset in the middle of traffic
        latRand = 1'b0;
        memLat = 2;
        repeat (5) cycle(1, 1);
        doReset();
        popPc.delete(); popData.delete(); popCyc.delete();
        repeat (10) cycle(1, 1);
        chk("post_reset_pc0", popAt(0), RESET_PC);
        chk("post_reset_pc1", popAt(1), RESET_PC + 32'd4);
        repeat (5) cycle(1, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
